// File: rtl/irq_controller.sv
// irq_controller: prioritised, vectored interrupt controller with edge capture,
// fixed lowest-index-wins arbitration and EOI hold-off. Define IRQ_SYNC_EN for a 2-flop irqSrc synchroniser.
module irq_controller #(
  parameter int NSRC  = 8,
  parameter int VEC_W = 12
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [NSRC-1:0]  irqSrc,
  input  logic             cfgWrEn,
  input  logic [3:0]       cfgAddr,
  input  logic [31:0]      cfgData,
  output logic [31:0]      cfgRdData,
  output logic             IRQ,
  output logic [VEC_W-1:0] IRQn,
  input  logic             IRQAck,
  output logic             busy
);

  // state   | meaning
  // IDLE    | arbitrating pending & enabled sources (deferred while IRQAck=1)
  // REQ     | IRQ raised with latched vector, waiting for IRQAck
  // SERVICE | acknowledged, busy held until software writes EOI
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_ENABLE  = 4'd0;
  localparam logic [3:0] ADDR_PENDING = 4'd1;
  localparam logic [3:0] ADDR_EOI     = 4'd2;

  state_t            state_q;
  logic              irq_q;
  logic [VEC_W-1:0]  irqn_q;
  logic              busy_q;
  logic [2:0]        active_id_q;
  logic [NSRC-1:0]   enable_q;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   irq_prev_q;
  logic [VEC_W-1:0]  vector_q [NSRC];
  logic [31:0]       rd_data_q, rd_data_d;

  logic [NSRC-1:0]   src_s;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   req_vec;
  logic [NSRC-1:0]   win_oh;
  logic [2:0]        win_id;
  logic [VEC_W-1:0]  win_vec;
  logic              grant;
  logic              wr_enable, wr_pending, wr_eoi;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfgData[31:VEC_W];

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irqSrc;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irqSrc;
`endif

  assign wr_enable  = cfgWrEn && (cfgAddr == ADDR_ENABLE);
  assign wr_pending = cfgWrEn && (cfgAddr == ADDR_PENDING);
  assign wr_eoi     = cfgWrEn && (cfgAddr == ADDR_EOI);

  // irqPrev resets to 0 so a line already high at reset release counts as an edge
  assign rise    = src_s & ~irq_prev_q;
  assign req_vec = pending_q & enable_q;
  assign grant   = (state_q == S_IDLE) && !IRQAck && (|req_vec);

  always_comb begin
    win_id  = '0;
    win_oh  = '0;
    win_vec = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_id     = 3'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
        win_vec    = vector_q[i];
      end
    end
  end

  // New edges are applied last so they win over both W1C and the grant clear
  always_comb begin
    pending_d = pending_q;
    if (wr_pending) begin
      pending_d = pending_d & ~cfgData[NSRC-1:0];
    end
    if (grant) begin
      pending_d = pending_d & ~win_oh;
    end
    pending_d = pending_d | rise;
  end

  always_comb begin
    rd_data_d = '0;
    case (cfgAddr)
      ADDR_ENABLE:  rd_data_d[NSRC-1:0] = enable_q;
      ADDR_PENDING: rd_data_d[NSRC-1:0] = pending_q;
      ADDR_EOI:     rd_data_d = {busy_q, 28'd0, active_id_q};
      default: begin
        for (int i = 0; i < NSRC; i++) begin
          if (cfgAddr == 4'(8 + i)) begin
            rd_data_d[VEC_W-1:0] = vector_q[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      enable_q   <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      rd_data_q  <= '0;
      for (int i = 0; i < NSRC; i++) begin
        vector_q[i] <= '0;
      end
    end else begin
      irq_prev_q <= src_s;
      pending_q  <= pending_d;
      rd_data_q  <= rd_data_d;
      if (wr_enable) begin
        enable_q <= cfgData[NSRC-1:0];
      end
      for (int i = 0; i < NSRC; i++) begin
        if (cfgWrEn && (cfgAddr == 4'(8 + i))) begin
          vector_q[i] <= cfgData[VEC_W-1:0];
        end
      end
    end
  end

  // IRQn is latched at grant, so later VECTOR/ENABLE writes cannot disturb a live request
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      irq_q       <= 1'b0;
      irqn_q      <= '0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            active_id_q <= win_id;
            irqn_q      <= win_vec;
            irq_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (IRQAck) begin
            irq_q   <= 1'b0;
            state_q <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (wr_eoi) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign IRQ       = irq_q;
  assign IRQn      = irqn_q;
  assign busy      = busy_q;
  assign cfgRdData = rd_data_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic, every cycle compared
// against a cycle-level behavioural model of the interrupt controller.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        nRst;
  logic [7:0]  irqSrc;
  logic        cfgWrEn;
  logic [3:0]  cfgAddr;
  logic [31:0] cfgData;
  logic [31:0] cfgRdData;
  logic        IRQ;
  logic [11:0] IRQn;
  logic        IRQAck;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_controller #(.NSRC(8), .VEC_W(12)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .irqSrc    (irqSrc),
    .cfgWrEn   (cfgWrEn),
    .cfgAddr   (cfgAddr),
    .cfgData   (cfgData),
    .cfgRdData (cfgRdData),
    .IRQ       (IRQ),
    .IRQn      (IRQn),
    .IRQAck    (IRQAck),
    .busy      (busy)
  );

  // reference model: phase 0 = free, 1 = waiting for ack, 2 = waiting for EOI
  logic [7:0]  m_prev, m_pend, m_en;
  int          m_vec [8];
  logic        m_irq, m_busy;
  int          m_irqn, m_act, m_phase;
  logic [31:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] rise, pend_n;
    int a;
    bit found;
    if (!nRst) begin
      m_prev = '0; m_pend = '0; m_en = '0;
      for (int i = 0; i < 8; i++) m_vec[i] = 0;
      m_irq = 1'b0; m_busy = 1'b0; m_irqn = 0; m_act = 0; m_phase = 0; m_rd = '0;
      return;
    end
    a = int'(cfgAddr);
    if (a == 0)      m_rd = {24'd0, m_en};
    else if (a == 1) m_rd = {24'd0, m_pend};
    else if (a == 2) m_rd = (m_busy ? 32'h8000_0000 : 32'h0) | 32'(m_act);
    else if (a >= 8) m_rd = 32'(m_vec[a - 8]);
    else             m_rd = '0;

    rise   = irqSrc & ~m_prev;
    m_prev = irqSrc;
    pend_n = m_pend;
    if (cfgWrEn && a == 1) pend_n = pend_n & ~cfgData[7:0];

    if (m_phase == 0) begin
      if (!IRQAck && (m_pend & m_en) != 8'd0) begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (!found && m_pend[i] && m_en[i]) begin
            found = 1'b1;
            m_act = i;
          end
        end
        m_irqn = m_vec[m_act];
        m_irq = 1'b1;
        m_busy = 1'b1;
        pend_n[m_act] = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (IRQAck) begin
        m_irq = 1'b0;
        m_phase = 2;
      end
    end else begin
      if (cfgWrEn && a == 2) begin
        m_busy = 1'b0;
        m_phase = 0;
      end
    end

    m_pend = pend_n | rise;
    if (cfgWrEn && a == 0) m_en = cfgData[7:0];
    if (cfgWrEn && a >= 8) m_vec[a - 8] = int'(cfgData[11:0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("irq",    32'(IRQ),  32'(m_irq));
    chk("irqn",   32'(IRQn), 32'(m_irqn));
    chk("busy",   32'(busy), 32'(m_busy));
    chk("rddata", cfgRdData, m_rd);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfgWrEn = 1'b1;
    cfgAddr = a;
    cfgData = d;
    cyc();
    cfgWrEn = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    cfgAddr = a;
    cyc();
  endtask

  initial begin
    nRst = 1'b0; irqSrc = '0; cfgWrEn = 1'b0; cfgAddr = '0; cfgData = '0; IRQAck = 1'b0;

    // reset and read-back of the main registers
    cyc(); cyc();
    nRst = 1'b1;
    rd(4'd0); chk("rst_enable", cfgRdData, 32'h0);
    rd(4'd1); chk("rst_pending", cfgRdData, 32'h0);
    rd(4'd2); chk("rst_status", cfgRdData, 32'h0);
    rd(4'd8); chk("rst_vector0", cfgRdData, 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);

    // single source, ack, status, EOI
    wr(4'd11, 32'h120);
    wr(4'd0, 32'h08);
    irqSrc = 8'h08; cyc();
    irqSrc = 8'h00; cyc();
    chk("t2_irq", 32'(IRQ), 32'h1);
    chk("t2_irqn", 32'(IRQn), 32'h120);
    IRQAck = 1'b1; cyc();
    chk("t2_irq_after_ack", 32'(IRQ), 32'h0);
    IRQAck = 1'b0;
    rd(4'd2); chk("t2_status", cfgRdData, 32'h8000_0003);
    wr(4'd2, 32'h0);
    chk("t2_eoi_busy", 32'(busy), 32'h0);

    // simultaneous sources 2 and 5: lowest index first
    wr(4'd0, 32'hFF);
    wr(4'd10, 32'h200);
    wr(4'd13, 32'h500);
    irqSrc = 8'h24; cyc();
    irqSrc = 8'h00; cyc();
    chk("t3_first_irq", 32'(IRQ), 32'h1);
    chk("t3_first_vec", 32'(IRQn), 32'h200);
    IRQAck = 1'b1; cyc();
    IRQAck = 1'b0;
    wr(4'd2, 32'h0);
    cyc();
    chk("t3_second_irq", 32'(IRQ), 32'h1);
    chk("t3_second_vec", 32'(IRQn), 32'h500);
    IRQAck = 1'b1; cyc();
    IRQAck = 1'b0;
    wr(4'd2, 32'h0);

    // pending latches while disabled, grant one cycle after enable
    wr(4'd0, 32'h00);
    irqSrc = 8'h02; cyc();
    irqSrc = 8'h00;
    rd(4'd1);
    chk("t4_pending", cfgRdData, 32'h02);
    chk("t4_irq_disabled", 32'(IRQ), 32'h0);
    wr(4'd0, 32'h02);
    chk("t4_irq_same_cycle", 32'(IRQ), 32'h0);
    cyc();
    chk("t4_irq_enabled", 32'(IRQ), 32'h1);
    IRQAck = 1'b1; cyc();
    IRQAck = 1'b0;
    wr(4'd2, 32'h0);

    // IRQAck held after EOI defers the request; W1C loses to a new edge
    wr(4'd0, 32'h01);
    irqSrc = 8'h01; cyc();
    cyc();
    IRQAck = 1'b1; cyc();
    IRQAck = 1'b0; irqSrc = 8'h00; cyc();
    irqSrc = 8'h01; cyc();
    IRQAck = 1'b1;
    wr(4'd2, 32'h0);
    cyc(); cyc();
    chk("t5_ack_hold", 32'(IRQ), 32'h0);
    IRQAck = 1'b0; cyc();
    chk("t5_after_ack_low", 32'(IRQ), 32'h1);
    IRQAck = 1'b1; cyc();
    IRQAck = 1'b0;
    irqSrc = 8'h00; cyc();
    irqSrc = 8'h01;
    cfgWrEn = 1'b1; cfgAddr = 4'd1; cfgData = 32'h01;
    cyc();
    cfgWrEn = 1'b0;
    rd(4'd1);
    chk("t5_w1c_vs_edge", cfgRdData, 32'h01);

    // reset while in service
    irqSrc = 8'h00;
    nRst = 1'b0; cyc();
    chk("t6_irq", 32'(IRQ), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    nRst = 1'b1;
    rd(4'd0); chk("t6_enable", cfgRdData, 32'h0);
    rd(4'd1); chk("t6_pending", cfgRdData, 32'h0);
    rd(4'd2); chk("t6_status", cfgRdData, 32'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) irqSrc[b] = ~irqSrc[b];
      end
      IRQAck  = ($urandom_range(0, 3) == 0);
      cfgWrEn = ($urandom_range(0, 5) == 0);
      cfgAddr = 4'($urandom_range(0, 15));
      if (cfgWrEn && $urandom_range(0, 9) < 3) cfgAddr = 4'd2;
      cfgData = $urandom();
      nRst    = ($urandom_range(0, 399) != 0);
      cyc();
    end
    nRst = 1'b1; cfgWrEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised, vectored interrupt controller that drives the CPU core's IRQ / IRQn / IRQAck handshake.
- Latches edges on NSRC peripheral interrupt lines, arbitrates by fixed priority, and presents the 12-bit ISR entry address to the core.
- Holds off further requests until software writes end-of-interrupt (EOI).
- Configured through a small memory-mapped register port on the data bus.

Parameters:
NSRC, 8, number of interrupt sources (1..8)
VEC_W, 12, vector width; matches the instruction address width

Ports:
clk  input  1  system clock, all logic on rising edge
nRst  input  1  reset, synchronous, active-low
irqSrc  input  NSRC  peripheral interrupt lines, rising-edge sensitive
cfgWrEn  input  1  register write strobe
cfgAddr  input  4  register address
cfgData  input  32  register write data
cfgRdData  output  32  register read data, registered
IRQ  output  1  interrupt request to core
IRQn  output  VEC_W  vector address to core, valid while IRQ=1
IRQAck  input  1  acknowledge from core
busy  output  1  high from grant until EOI

Behaviour:
- Reset (nRst=0 at clk edge):
  - IRQ=0, IRQn=0, busy=0, cfgRdData=0.
  - ENABLE=0, PENDING=0, all VECTOR=0, activeId=0, irqPrev=0, state IDLE.
  - A source already high when reset releases registers as an edge.
  - Reset asserted mid-service returns everything to this state with no EOI needed.
- Register map:
  - 0: ENABLE[NSRC-1:0], RW.
  - 1: PENDING. Read returns pending bits. Write-1-to-clear.
  - 2: EOI/STATUS. Write of any value = EOI. Read = {busy at bit 31, activeId at [2:0]}.
  - 8+i: VECTOR[i][11:0], RW, for i < NSRC.
  - Undefined addresses read 0; writes to them are ignored.
- cfgRdData: updated every cycle from cfgAddr, so reads have one-cycle latency.
- Edge capture:
  - irqPrev <= irqSrc every cycle.
  - pending[i] sets when irqSrc[i] & ~irqPrev[i].
  - Pending latches regardless of ENABLE.
  - A repeated edge while pending is already set is lost; there is no counting.
  - Write-1-clear and a new edge in the same cycle: set wins.
- Arbitration happens in IDLE only.
  - Request condition: IRQAck=0 and (PENDING & ENABLE) != 0.
  - Winner is the lowest index i.
  - Next edge actions: activeId<=i, IRQn<=VECTOR[i], IRQ<=1, busy<=1, pending[i]<=0, go to REQ.
  - If IRQAck=1 in IDLE, the request is deferred; this covers the core not yet having returned to FETCH.
- Latency: source edge sampled at edge k -> pending=1 after k -> IRQ=1 after k+1, when IDLE.
- State machine:
  - IDLE: arbitrate as above.
  - REQ: hold IRQ and IRQn stable. When IRQAck=1 is sampled: IRQ<=0, go to SERVICE.
  - SERVICE: wait for an EOI write, then busy<=0 and go to IDLE.
- EOI rules:
  - EOI written in IDLE or REQ is ignored.
  - An EOI write and a new edge in the same cycle: both take effect.
  - After EOI, the earliest re-request is the following cycle, subject to IRQAck=0.
- Configuration changes during a request:
  - A VECTOR write during REQ/SERVICE does not change the latched IRQn.
  - Clearing ENABLE during REQ does not withdraw the request.
- IRQn holds its last value when IRQ=0.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irqSrc passes a 2-flop synchroniser (reset 0) before edge detection. Edge-to-pending latency grows by 2 cycles (IRQ after k+3).
- Undefined: irqSrc is used directly and is treated as synchronous to clk.

Test Plan:
- Reset, then read addresses 0, 1, 2 and 8 -> all read 0 one cycle after address; IRQ=0.
- Set VECTOR[3]=0x120 and ENABLE=0x08. Pulse irqSrc[3] at edge k -> IRQ=1 and IRQn=0x120 after k+1. Drive IRQAck=1 -> IRQ=0 next cycle; STATUS reads 0x80000003. Write EOI -> busy=0.
- ENABLE=0xFF. Raise irqSrc[5] and irqSrc[2] in the same cycle -> source 2 granted first. After IRQAck low and EOI, source 5 is granted with VECTOR[5].
- irqSrc[1] edge with ENABLE=0 -> PENDING reads 0x02 and IRQ stays 0. Then set ENABLE=0x02 -> IRQ asserts 1 cycle later.
- Hold IRQAck=1 after EOI with source 0 pending -> no IRQ until IRQAck=0. Write PENDING=0x01 in the same cycle as a new edge on source 0 -> bit stays set.
- Assert nRst=0 during SERVICE -> IRQ=0, busy=0, state IDLE; pending and enable cleared.
